maze_job_scheduler: RTL and testbench

Front-end controller that shares one serial maze solver core among N_REQ maze sources. It arbitrates round-robin among requesting sources and streams the granted source's 225-bit maze into the solver. It forwards the solver's coordinate/verdict beats back, tagged with the requester id, then closes each job with a done record. A watchdog recovers the solver through a local reset if a job hangs.

---
 rtl/maze_job_scheduler.sv | 124 ++++++++++++
 tb/tb_maze_job_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_job_scheduler.sv
// maze_job_scheduler: round-robin front end sharing one serial maze solver among N_REQ sources
module maze_job_scheduler #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int MAZE_BITS = 225,
  parameter int TIMEOUT   = 1023,
  parameter int MAX_BEATS = 225,
  parameter int GAP_CYC   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_bit,
  output logic [N_REQ-1:0] req_rd,
  output logic [N_REQ-1:0] grant,
  output logic             sol_maze,
  output logic             sol_in_valid,
  output logic             sol_rst_n,
  input  logic             sol_out_valid,
  input  logic             sol_not_valid,
  input  logic [3:0]       sol_x,
  input  logic [3:0]       sol_y,
  output logic             rsp_valid,
  output logic [ID_W-1:0]  rsp_id,
  output logic [3:0]       rsp_x,
  output logic [3:0]       rsp_y,
  output logic             rsp_not_valid,
  output logic             done_valid,
  output logic [ID_W-1:0]  done_id,
  output logic [1:0]       done_status,
  output logic [7:0]       done_len,
  output logic             busy
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, RESULT, ABORT, GAP} state_t;
  localparam logic [15:0] LOAD_LAST = 16'(MAZE_BITS - 1);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);
  localparam logic [15:0] BEAT_MAX  = 16'(MAX_BEATS);
  state_t state, nxt;
  logic [ID_W-1:0] ptr, id, pick;
  logic [N_REQ-1:0] pick_oh;
  logic [2*N_REQ-1:0] dbl;
  logic [15:0] cnt, beats;
  logic any, nv, fwd, fin;
  assign dbl = {req, req} >> ptr;
  assign pick_oh = N_REQ'(1) << pick;
  assign fwd = nxt == RESULT;
  assign fin = nxt == GAP && state != GAP;
  // round-robin search: first requester at or after ptr, wrapping
  always_comb begin
    pick = '0;
    any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (dbl[k]) begin
        pick = ID_W'((int'(ptr) + k) % N_REQ);
        any = 1'b1;
      end
  end
  // next-state selection; a beat is forwarded exactly when the next state is RESULT
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = any ? LOAD : IDLE;
      LOAD:    nxt = cnt == LOAD_LAST ? WAIT : LOAD;
      WAIT:    nxt = sol_out_valid ? RESULT : cnt == WAIT_LAST ? ABORT : WAIT;
      RESULT:  nxt = !sol_out_valid ? GAP : beats == BEAT_MAX ? ABORT : RESULT;
      ABORT:   nxt = cnt == 16'd1 ? GAP : ABORT;
      GAP:     nxt = cnt == GAP_LAST ? IDLE : GAP;
      default: nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // job bookkeeping and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ptr <= '0;
      id <= '0;
      beats <= '0;
      nv <= 1'b0;
      grant <= '0;
      req_rd <= '0;
      sol_in_valid <= 1'b0;
      sol_maze <= 1'b0;
      sol_rst_n <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_x <= '0;
      rsp_y <= '0;
      rsp_not_valid <= 1'b0;
      done_valid <= 1'b0;
      done_id <= '0;
      done_status <= '0;
      done_len <= '0;
      busy <= 1'b0;
    end else begin
      cnt <= nxt != state ? '0 : cnt + 16'd1;
      if (state == IDLE && any) begin
        id <= pick;
        ptr <= ID_W'((int'(pick) + 1) % N_REQ);
      end
      grant <= state == IDLE && any ? pick_oh : nxt == GAP ? '0 : grant;
      req_rd <= nxt == LOAD ? (state == IDLE ? pick_oh : grant) : '0;
      sol_in_valid <= state == LOAD;
      sol_maze <= state == LOAD && |(req_bit & grant);
      sol_rst_n <= nxt != ABORT;
      rsp_valid <= fwd;
      rsp_id <= fwd ? id : '0;
      rsp_x <= fwd ? sol_x : '0;
      rsp_y <= fwd ? sol_y : '0;
      rsp_not_valid <= fwd && sol_not_valid;
      beats <= state == IDLE ? '0 : fwd ? beats + 16'd1 : beats;
      nv <= state == IDLE ? 1'b0 : nv | (fwd & sol_not_valid);
      done_valid <= fin;
      done_id <= fin ? id : '0;
      done_status <= !fin ? 2'b00 : state == ABORT ? 2'b10 : {1'b0, nv};
      done_len <= !fin ? 8'd0 : beats > 16'd255 ? 8'hff : beats[7:0];
      busy <= nxt != IDLE;
    end
  end
endmodule

// File: tb/tb_maze_job_scheduler.sv
// tb_maze_job_scheduler: randomized scoreboard bench for the maze job scheduler
module tb_maze_job_scheduler;
  localparam int N = 4;
  localparam int MB = 225;
  localparam int TO = 1023;
  localparam int MAXB = 225;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] req_bit = '0;
  logic [N-1:0] req_rd, grant;
  logic sol_maze, sol_in_valid, sol_rst_n;
  logic sol_out_valid = 1'b0;
  logic sol_not_valid = 1'b0;
  logic [3:0] sol_x = '0;
  logic [3:0] sol_y = '0;
  logic rsp_valid, rsp_not_valid, done_valid, busy;
  logic [1:0] rsp_id, done_id, done_status;
  logic [3:0] rsp_x, rsp_y;
  logic [7:0] done_len;
  int nvec = 0;
  int nerr = 0;

  typedef struct packed { logic [1:0] id; logic [3:0] x; logic [3:0] y; logic nv; } beat_t;
  typedef struct packed { logic [1:0] id; logic [1:0] st; logic [7:0] len; } done_t;
  int gq[$];
  beat_t rq[$];
  done_t dq[$];
  logic [MB-1:0] mz [N];
  int pos [N];
  int n_done = 0;
  int eptr = 0;
  bit to_job = 0;

  maze_job_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_bit(req_bit), .req_rd(req_rd), .grant(grant),
    .sol_maze(sol_maze), .sol_in_valid(sol_in_valid), .sol_rst_n(sol_rst_n),
    .sol_out_valid(sol_out_valid), .sol_not_valid(sol_not_valid), .sol_x(sol_x), .sol_y(sol_y),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_y(rsp_y),
    .rsp_not_valid(rsp_not_valid), .done_valid(done_valid), .done_id(done_id),
    .done_status(done_status), .done_len(done_len), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    nvec++;
    nerr++;
    $display("FAIL %s: event not seen within its bound (required: seen)", name);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // reference arbiter: first requester at or after the model pointer, modulo N
  function automatic int rr(input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(eptr + k) % N]) return (eptr + k) % N;
    return -1;
  endfunction

  // each source presents the next bit of its maze whenever it is strobed
  always @(negedge clk)
    for (int s = 0; s < N; s++)
      if (req_rd[s]) begin
        req_bit[s] = mz[s][pos[s]];
        pos[s]++;
      end else begin
        req_bit[s] = 1'($urandom);
        pos[s] = 0;
      end

  // monitor: pops expectations whenever the DUT presents something
  logic [N-1:0] gprev;
  logic [MB-1:0] rx;
  int cur = 0;
  int inv_run = 0;
  int rst_run = 0;
  int cyc = 0;
  int inv_last = 0;
  beat_t b;
  done_t d;
  always @(negedge clk) begin
    if (!rst_n) begin
      gprev = '0;
      inv_run = 0;
      rst_run = 0;
    end else begin
      cyc++;
      if (grant != 0 || req_rd != 0) begin
        chk("grant_onehot", 32'($onehot(grant)), 1);
        chk("rd_within_grant", 32'(req_rd & ~grant), 0);
      end
      if (gprev == 0 && grant != 0) begin
        if (gq.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL grant_unexpected: got grant 0x%0h, required none", grant);
        end else begin
          cur = gq.pop_front();
          chk("grant", 32'(grant), 32'(1 << cur));
        end
      end
      gprev = grant;
      if (sol_in_valid) begin
        if (inv_run < MB) rx[inv_run] = sol_maze;
        inv_run++;
        inv_last = cyc;
      end else if (inv_run != 0) begin
        chk("load_len", inv_run, MB);
        chk("maze_bits", 32'(rx == mz[cur]), 1);
        inv_run = 0;
      end
      if (!sol_rst_n) begin
        rst_run++;
        if (rst_run == 1 && to_job) chk("timeout_cycles", cyc - inv_last, TO);
      end else if (rst_run != 0) begin
        chk("sol_rst_len", rst_run, 2);
        rst_run = 0;
      end
      if (rsp_valid) begin
        if (rq.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL rsp_unexpected: got id=%0d x=%0d y=%0d nv=%0d, required none", rsp_id, rsp_x, rsp_y, rsp_not_valid);
        end else begin
          b = rq.pop_front();
          chk("rsp_beat", 32'({rsp_id, rsp_x, rsp_y, rsp_not_valid}), 32'(b));
        end
      end
      if (done_valid) begin
        n_done++;
        if (dq.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL done_unexpected: got id=%0d status=%0d len=%0d, required none", done_id, done_status, done_len);
        end else begin
          d = dq.pop_front();
          chk("done_rec", 32'({done_id, done_status, done_len}), 32'(d));
        end
      end
    end
  end

  // kind: 0 normal beats, 1 silent solver, 2 endless beats, 3 reset at load bit 100
  task automatic run_job(input logic [N-1:0] r, input int kind, input bit hold, input int nb, input int nv_at);
    int g, t, seen, d0;
    bit any_nv;
    for (int s = 0; s < N; s++)
      for (int i = 0; i < MB; i++) mz[s][i] = 1'($urandom);
    req = r;
    g = rr(r);
    eptr = (g + 1) % N;
    gq.push_back(g);
    t = 0;
    while (grant == 0 && t < 40) begin tick(); t++; end
    if (grant == 0) begin fail("grant_wait"); return; end
    if (!hold) req = '0;
    seen = 0;
    t = 0;
    while (!sol_in_valid && t < 10) begin tick(); t++; end
    while (sol_in_valid && t < 400) begin
      seen++;
      if (kind == 3 && seen == 100) begin
        rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 0);
        chk("arst_req_rd", 32'(req_rd), 0);
        chk("arst_in_valid", 32'(sol_in_valid), 0);
        chk("arst_sol_rst_n", 32'(sol_rst_n), 1);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_rsp_done", 32'({rsp_valid, done_valid}), 0);
        eptr = 0;
        req = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        return;
      end
      sol_out_valid = (seen >= 20 && seen < 30) ? 1'($urandom) : 1'b0;
      sol_not_valid = 1'($urandom);
      tick();
      t++;
    end
    sol_out_valid = 1'b0;
    if (seen == 0 || sol_in_valid) begin fail("load_wait"); return; end
    d0 = n_done;
    if (kind == 0) begin
      repeat ($urandom_range(0, 4)) tick();
      any_nv = 0;
      for (int i = 0; i < nb; i++) begin
        sol_out_valid = 1'b1;
        sol_x = 4'($urandom);
        sol_y = 4'($urandom);
        sol_not_valid = i == nv_at;
        any_nv |= sol_not_valid;
        rq.push_back({2'(g), sol_x, sol_y, sol_not_valid});
        tick();
      end
      sol_out_valid = 1'b0;
      sol_not_valid = 1'($urandom);
      dq.push_back({2'(g), any_nv ? 2'b01 : 2'b00, 8'(nb)});
    end else if (kind == 1) begin
      to_job = 1;
      dq.push_back({2'(g), 2'b10, 8'd0});
    end else begin
      dq.push_back({2'(g), 2'b10, 8'(MAXB)});
      for (int i = 0; i < 300; i++) begin
        sol_out_valid = 1'b1;
        sol_x = 4'($urandom);
        sol_y = 4'($urandom);
        sol_not_valid = 1'($urandom);
        if (i < MAXB) rq.push_back({2'(g), sol_x, sol_y, sol_not_valid});
        tick();
      end
      sol_out_valid = 1'b0;
    end
    t = 0;
    while (n_done == d0 && t < 1500) begin tick(); t++; end
    if (n_done == d0) fail("done_wait");
    to_job = 0;
  endtask

  initial begin
    int nb;
    repeat (3) tick();
    chk("rst_grant_rd", 32'({grant, req_rd}), 0);
    chk("rst_sol", 32'({sol_in_valid, sol_maze, sol_rst_n}), 1);
    chk("rst_rsp", 32'({rsp_valid, rsp_id, rsp_x, rsp_y, rsp_not_valid}), 0);
    chk("rst_done", 32'({done_valid, done_id, done_status, done_len}), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick();
    for (int j = 0; j < 5; j++) run_job(4'b1111, 0, 1, $urandom_range(1, 12), -1);
    run_job(4'b0100, 0, 0, 25, -1);
    run_job(4'b0010, 0, 0, 1, 0);
    for (int j = 0; j < 6; j++) begin
      nb = $urandom_range(1, 20);
      run_job(4'($urandom_range(1, 15)), 0, 0, nb, $urandom_range(0, nb));
    end
    run_job(4'b1000, 1, 0, 0, -1);
    run_job(4'b0001, 2, 0, 0, -1);
    run_job(4'b0100, 3, 0, 0, -1);
    run_job(4'b1010, 0, 0, 5, -1);
    repeat (10) tick();
    chk("grant_queue_empty", gq.size(), 0);
    chk("rsp_queue_empty", rq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run still active, got %0d miscompares so far, required completion", nerr);
    $fatal(1, "watchdog expired");
  end
endmodule
